// File: rtl/seg_scan_capture.sv
// Reads back a multiplexed 4-digit seven-segment scan: synchronizes and debounces the
// anode/segment lines, decodes each digit to BCD and assembles complete frames.
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sysclock,
  input  logic        reset,
  input  logic [3:0]  annode,
  input  logic [7:0]  segs,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        bad_pattern,
  output logic [1:0]  scan_state
);

  typedef enum logic [1:0] {HUNT, EXP1, EXP2, EXP3} state_t;

  localparam logic [7:0]  STAB_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TMO_M1  = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  an_s1, an_s2, an_prev;
  logic [7:0]  sg_s1, sg_s2, sg_prev;
  logic [7:0]  stab_cnt;
  logic [15:0] tmo_cnt, tmo_nxt;
  state_t      state, state_nxt, adv_state;
  logic [3:0]  dig [4];
  logic [3:0]  dig_dp;
  logic        load_pend, load_nxt;
  logic        err_nxt, store_en;
  logic        accept, blank, hit, one_hot, pat_ok, digit_ok;
  logic [1:0]  k;
  logic [3:0]  seg_bcd;

  assign scan_state = state;

  // The previous sample is the stable value once the counter has run up.
  assign accept = (stab_cnt == STAB_M1);
  assign blank  = (an_prev == 4'hF);
  assign hit    = accept && !blank;

  always_comb begin
    k       = 2'd0;
    one_hot = 1'b1;
    case (an_prev)
      4'hE:    k = 2'd0;
      4'hD:    k = 2'd1;
      4'hB:    k = 2'd2;
      4'h7:    k = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  always_comb begin
    seg_bcd = 4'd0;
    pat_ok  = 1'b1;
    case (sg_prev[6:0])
      7'h40:   seg_bcd = 4'd0;
      7'h79:   seg_bcd = 4'd1;
      7'h24:   seg_bcd = 4'd2;
      7'h30:   seg_bcd = 4'd3;
      7'h19:   seg_bcd = 4'd4;
      7'h12:   seg_bcd = 4'd5;
      7'h02:   seg_bcd = 4'd6;
      7'h78:   seg_bcd = 4'd7;
      7'h00:   seg_bcd = 4'd8;
      7'h10:   seg_bcd = 4'd9;
      default: pat_ok = 1'b0;
    endcase
  end

  assign digit_ok = hit && one_hot && pat_ok;

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    err_nxt   = 1'b0;
    store_en  = 1'b0;
    load_nxt  = 1'b0;
    adv_state = HUNT;
    case (state)
      EXP1:    adv_state = EXP2;
      EXP2:    adv_state = EXP3;
      default: adv_state = HUNT;
    endcase
    if (state == HUNT) begin
      tmo_nxt = 16'd0;
      if (digit_ok && k == 2'd0) begin
        store_en  = 1'b1;
        state_nxt = EXP1;
      end
    end else begin
      tmo_nxt = tmo_cnt + 16'd1;
      if (hit) begin
        tmo_nxt = 16'd0;
        if (digit_ok && k == state) begin
          store_en  = 1'b1;
          state_nxt = adv_state;
          load_nxt  = (state == EXP3);
        end else if (digit_ok && k == 2'd0) begin
          // Restart: the scan wrapped early, keep the new ones digit.
          err_nxt   = 1'b1;
          store_en  = 1'b1;
          state_nxt = EXP1;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = HUNT;
        end
      end else if (tmo_cnt == TMO_M1) begin
        err_nxt   = 1'b1;
        state_nxt = HUNT;
        tmo_nxt   = 16'd0;
      end
    end
  end

  always_ff @(posedge sysclock) begin
    if (!reset) begin
      an_s1       <= 4'hF;
      an_s2       <= 4'hF;
      an_prev     <= 4'hF;
      sg_s1       <= 8'hFF;
      sg_s2       <= 8'hFF;
      sg_prev     <= 8'hFF;
      stab_cnt    <= 8'd0;
      tmo_cnt     <= 16'd0;
      state       <= HUNT;
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
      dig_dp      <= 4'h0;
      load_pend   <= 1'b0;
      value       <= 16'h0000;
      dp          <= 4'h0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      an_s1   <= annode;
      an_s2   <= an_s1;
      an_prev <= an_s2;
      sg_s1   <= segs;
      sg_s2   <= sg_s1;
      sg_prev <= sg_s2;
      if ({an_s2, sg_s2} != {an_prev, sg_prev}) stab_cnt <= 8'd0;
      else if (stab_cnt != 8'hFF)               stab_cnt <= stab_cnt + 8'd1;
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      if (store_en) begin
        dig[k]    <= seg_bcd;
        dig_dp[k] <= ~sg_prev[7];
      end
      load_pend   <= load_nxt;
      frame_valid <= load_pend;
      if (load_pend) begin
        value <= {dig[3], dig[2], dig[1], dig[0]};
        dp    <= dig_dp;
      end
      frame_err <= err_nxt;
      if (hit && !pat_ok) bad_pattern <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: table of full scans plus hand sequences for
// glitches, out-of-order digits, timeout, long blanking and mid-frame reset.
module tb_seg_scan_capture;

  localparam int STAB = 4;
  localparam int TMO  = 1024;

  logic        sysclock;
  logic        reset;
  logic [3:0]  annode;
  logic [7:0]  segs;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        frame_err;
  logic        bad_pattern;
  logic [1:0]  scan_state;

  seg_scan_capture #(.STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TMO)) dut (
    .sysclock(sysclock), .reset(reset), .annode(annode), .segs(segs),
    .value(value), .dp(dp), .frame_valid(frame_valid), .frame_err(frame_err),
    .bad_pattern(bad_pattern), .scan_state(scan_state)
  );

  // clock / reset
  initial sysclock = 1'b0;
  always #5 sysclock = ~sysclock;

  int cyc = 0;
  always @(posedge sysclock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pulse monitor, sampled on the falling edge
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int first_valid_cyc = -1;
  always @(negedge sysclock) begin
    if (frame_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    annode = a;
    segs   = s;
    repeat (n) @(negedge sysclock);
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic scan4(input logic [31:0] sw, input int per);
    for (int k = 0; k < 4; k++) hold(an_of(k), sw[8*k +: 8], per);
  endtask

  typedef struct {
    string       name;
    logic [31:0] sw;
    logic [15:0] exp_value;
    logic [3:0]  exp_dp;
    int          exp_valid;
    int          exp_err;
    logic        exp_bad;
  } row_t;

  row_t rows [5];
  int v0, e0, start_cyc;

  initial begin
    rows[0] = '{"scan1234", 32'hF9A4B099, 16'h1234, 4'h0, 1, 0, 1'b0};
    rows[1] = '{"scan5678", 32'h92827880, 16'h5678, 4'h2, 1, 0, 1'b0};
    rows[2] = '{"badpat",   32'hF9FEB099, 16'h5678, 4'h2, 0, 1, 1'b1};
    rows[3] = '{"clean",    32'hF9A4B099, 16'h1234, 4'h0, 1, 0, 1'b1};
    rows[4] = '{"scan9090", 32'h10401040, 16'h9090, 4'hF, 1, 0, 1'b1};

    // reset held low while an active scan is driven
    reset  = 1'b0;
    annode = 4'hE;
    segs   = 8'h99;
    @(negedge sysclock);
    hold(4'hE, 8'h99, 1);
    hold(4'hD, 8'hB0, 2);
    check("rst_value", 32'(value), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_bad", 32'(bad_pattern), 32'h0);
    check("rst_state", 32'(scan_state), 32'h0);
    check("rst_pulses", 32'(valid_cnt + err_cnt), 32'h0);
    reset = 1'b1;
    hold(4'hF, 8'hFF, 10);

    // table of full scans
    for (int r = 0; r < 5; r++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      if (r == 0) start_cyc = cyc;
      scan4(rows[r].sw, 20);
      hold(4'hF, 8'hFF, 20);
      check({rows[r].name, "_value"}, 32'(value), 32'(rows[r].exp_value));
      check({rows[r].name, "_dp"}, 32'(dp), 32'(rows[r].exp_dp));
      check({rows[r].name, "_valid"}, 32'(valid_cnt - v0), 32'(rows[r].exp_valid));
      check({rows[r].name, "_err"}, 32'(err_cnt - e0), 32'(rows[r].exp_err));
      check({rows[r].name, "_bad"}, 32'(bad_pattern), 32'(rows[r].exp_bad));
      if (r == 0) begin
        check("first_valid_seen", 32'(first_valid_cyc >= 0), 32'h1);
        check("first_valid_latency", 32'((first_valid_cyc - start_cyc) <= 80 + STAB + 3), 32'h1);
      end
    end

    // glitches: anode overlap at each transition and a one-cycle segs burst
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sw;
      sw = 32'hF9A4B099;
      hold(4'hC, sw[8*k +: 8], 1);
      hold(an_of(k), sw[8*k +: 8], 2);
      hold(an_of(k), 8'h00, 1);
      hold(an_of(k), sw[8*k +: 8], 16);
    end
    hold(4'hF, 8'hFF, 20);
    check("glitch_value", 32'(value), 32'h1234);
    check("glitch_valid", 32'(valid_cnt - v0), 32'h1);
    check("glitch_err", 32'(err_cnt - e0), 32'h0);

    // out of order: 0 then 2
    e0 = err_cnt;
    v0 = valid_cnt;
    hold(4'hE, 8'h99, 20);
    hold(4'hB, 8'hA4, 20);
    hold(4'hF, 8'hFF, 20);
    check("ooo02_err", 32'(err_cnt - e0), 32'h1);
    check("ooo02_valid", 32'(valid_cnt - v0), 32'h0);
    check("ooo02_state", 32'(scan_state), 32'h0);
    check("ooo02_value", 32'(value), 32'h1234);

    // restart: 0, 1, 0 then the scan continues 1, 2, 3
    e0 = err_cnt;
    v0 = valid_cnt;
    hold(4'hE, 8'h92, 20);
    hold(4'hD, 8'h82, 20);
    hold(4'hE, 8'h80, 20);
    hold(4'hD, 8'hF9, 20);
    hold(4'hB, 8'hA4, 20);
    hold(4'h7, 8'hB0, 20);
    hold(4'hF, 8'hFF, 20);
    check("restart_err", 32'(err_cnt - e0), 32'h1);
    check("restart_valid", 32'(valid_cnt - v0), 32'h1);
    check("restart_value", 32'(value), 32'h3218);

    // frozen on digit 1: a single timeout, not earlier than the limit
    e0 = err_cnt;
    v0 = valid_cnt;
    hold(4'hE, 8'h90, 20);
    hold(4'hD, 8'hC0, TMO - 24);
    check("tmo_early", 32'(err_cnt - e0), 32'h0);
    hold(4'hD, 8'hC0, 64);
    check("tmo_err", 32'(err_cnt - e0), 32'h1);
    check("tmo_valid", 32'(valid_cnt - v0), 32'h0);
    check("tmo_state", 32'(scan_state), 32'h0);
    check("tmo_value", 32'(value), 32'h3218);

    // long blanking in HUNT
    e0 = err_cnt;
    v0 = valid_cnt;
    hold(4'hF, 8'hFF, 5000);
    check("blank_pulses", 32'((err_cnt - e0) + (valid_cnt - v0)), 32'h0);

    // reset mid-frame discards partial digits and clears the sticky flag
    e0 = err_cnt;
    v0 = valid_cnt;
    hold(4'hE, 8'hF8, 20);
    hold(4'hD, 8'hF8, 20);
    reset = 1'b0;
    hold(4'hD, 8'hF8, 3);
    reset = 1'b1;
    hold(4'hB, 8'hF8, 20);
    hold(4'h7, 8'hF8, 20);
    hold(4'hF, 8'hFF, 20);
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_bad", 32'(bad_pattern), 32'h0);
    check("midrst_valid", 32'(valid_cnt - v0), 32'h0);
    check("midrst_err", 32'(err_cnt - e0), 32'h0);
    v0 = valid_cnt;
    scan4(32'h99B0A4F9, 20);
    hold(4'hF, 8'hFF, 20);
    check("post_rst_value", 32'(value), 32'h4321);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'h1);

    check("pulse_exclusive", 32'(both_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
